// File: rtl/rom_rr_arbiter_if.sv
// rtl/rom_rr_arbiter_if.sv - request/grant/read-data bundle between two requesters, the arbiter and a shared ROM
//
// Purpose: groups every non-clock signal of rom_rr_arbiter.
//   slave  modport : the arbiter's view (takes requests and ROM data, drives grants, read data, ROM address)
//   master modport : the requester/ROM side's view (the mirror image)
// Signals:
//   req0/req1       requester X read request (level, held until grant)
//   addr0/addr1     requester X read address, valid while reqX=1
//   gnt0/gnt1       one-cycle grant pulse
//   rvalid0/rvalid1 one-cycle read-data-valid pulse
//   rdata0/rdata1   read data, held until the next rvalidX
//   rom_a           registered address to the shared combinational ROM
//   rom_q           ROM data, combinational from rom_a
interface rom_rr_arbiter_if #(
  parameter int AW = 4,
  parameter int DW = 8
) ();
  logic          req0;
  logic          req1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic          gnt0;
  logic          gnt1;
  logic          rvalid0;
  logic          rvalid1;
  logic [DW-1:0] rdata0;
  logic [DW-1:0] rdata1;
  logic [AW-1:0] rom_a;
  logic [DW-1:0] rom_q;

  modport slave (
    input  req0, req1, addr0, addr1, rom_q,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, rom_a
  );

  modport master (
    output req0, req1, addr0, addr1, rom_q,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, rom_a
  );
endinterface

// File: rtl/rom_rr_arbiter.sv
// rtl/rom_rr_arbiter.sv - two-requester round-robin arbiter for one shared combinational ROM port
//
// Purpose: shares a single ROM read port between two requesters, at most one
// grant per clock. A grant at edge E0 issues the address; the data returned by
// the ROM is captured at the next edge E1 for the requester that owned the read.
// Grant and capture are pipelined, so alternating requesters get one read per cycle.
// Ports:
//   clk    input   single clock, all state updates on its rising edge
//   rst_n  input   asynchronous active-low reset
//   bus    slave   request/grant/read-data/ROM signals (see rom_rr_arbiter_if)
module rom_rr_arbiter #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  rom_rr_arbiter_if.slave  bus
);

  logic          r_gnt0;
  logic          r_gnt1;
  logic          r_rvalid0;
  logic          r_rvalid1;
  logic [DW-1:0] r_rdata0;
  logic [DW-1:0] r_rdata1;
  logic [AW-1:0] r_rom_a;
  logic          r_owner;   // requester that owns the read currently on rom_a
  logic          r_rr;      // requester preferred on contention (not granted most recently)
  logic          r_pend;    // a read was issued at the previous edge; capture rom_q at this one

  logic          w_elig0;
  logic          w_elig1;
  logic          w_win0;
  logic          w_win1;

  // A requester sees its grant one cycle late and only then drops req, so its
  // request is masked during the cycle its grant pulse is high.
  assign w_elig0 = bus.req0 & ~r_gnt0;
  assign w_elig1 = bus.req1 & ~r_gnt1;

  // Sole eligible requester wins outright; on contention the pointer decides.
  assign w_win0  = w_elig0 & (~w_elig1 | ~r_rr);
  assign w_win1  = w_elig1 & (~w_elig0 |  r_rr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_rdata0  <= '0;
      r_rdata1  <= '0;
      r_rom_a   <= '0;
      r_owner   <= 1'b0;
      r_rr      <= 1'b0;
      r_pend    <= 1'b0;
    end else begin
      // Issue stage
      r_gnt0 <= w_win0;
      r_gnt1 <= w_win1;
      r_pend <= w_win0 | w_win1;
      if (w_win0) begin
        r_rom_a <= bus.addr0;
        r_owner <= 1'b0;
        r_rr    <= 1'b1;
      end else if (w_win1) begin
        r_rom_a <= bus.addr1;
        r_owner <= 1'b1;
        r_rr    <= 1'b0;
      end

      // Capture stage: uses the owner/address from the previous edge, so a new
      // grant on this same edge does not disturb the read being completed.
      r_rvalid0 <= r_pend & ~r_owner;
      r_rvalid1 <= r_pend &  r_owner;
      if (r_pend && !r_owner) begin
        r_rdata0 <= bus.rom_q;
      end
      if (r_pend && r_owner) begin
        r_rdata1 <= bus.rom_q;
      end
    end
  end

  assign bus.gnt0    = r_gnt0;
  assign bus.gnt1    = r_gnt1;
  assign bus.rvalid0 = r_rvalid0;
  assign bus.rvalid1 = r_rvalid1;
  assign bus.rdata0  = r_rdata0;
  assign bus.rdata1  = r_rdata1;
  assign bus.rom_a   = r_rom_a;

endmodule

// File: tb/tb_rom_rr_arbiter.sv
// tb/tb_rom_rr_arbiter.sv - self-checking bench for rom_rr_arbiter
module tb_rom_rr_arbiter;
  localparam int AW = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rom_rr_arbiter_if #(.AW(AW), .DW(DW)) bus ();
  rom_rr_arbiter #(.AW(AW), .DW(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [DW-1:0] rom [16];
  assign bus.rom_q = rom[bus.rom_a];

  int total = 0;
  int bad = 0;

  // Reference model: outstanding reads as a queue of (due cycle, requester, address);
  // fairness tracked as "who was served last".
  typedef struct {
    int due;
    int who;
    int addr;
  } rd_t;
  rd_t pend[$];
  int cyc = 0;
  int last_served = 1;
  logic          m_gnt0, m_gnt1, m_rv0, m_rv1;
  logic [DW-1:0] m_rd0, m_rd1;
  logic [AW-1:0] m_rom_a;
  int n_gnt0 = 0, n_gnt1 = 0, n_rv1 = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    cyc = 0;
    last_served = 1;
    m_gnt0 = 0; m_gnt1 = 0; m_rv0 = 0; m_rv1 = 0;
    m_rd0 = '0; m_rd1 = '0; m_rom_a = '0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".gnt0"}, bus.gnt0, m_gnt0);
    chk({tag, ".gnt1"}, bus.gnt1, m_gnt1);
    chk({tag, ".rvalid0"}, bus.rvalid0, m_rv0);
    chk({tag, ".rvalid1"}, bus.rvalid1, m_rv1);
    chk({tag, ".rdata0"}, bus.rdata0, m_rd0);
    chk({tag, ".rdata1"}, bus.rdata1, m_rd1);
    chk({tag, ".rom_a"}, bus.rom_a, m_rom_a);
    chk({tag, ".gnt_excl"}, bus.gnt0 & bus.gnt1, 0);
    chk({tag, ".rv_excl"}, bus.rvalid0 & bus.rvalid1, 0);
    n_gnt0 += int'(bus.gnt0);
    n_gnt1 += int'(bus.gnt1);
    n_rv1  += int'(bus.rvalid1);
  endtask

  // Predict the effect of the next rising edge from the inputs currently driven,
  // then advance one edge and compare.
  task automatic tick(input string tag);
    bit e0, e1;
    int who, a;
    rd_t r;
    if (!rst_n) begin
      model_reset();
    end else begin
      e0 = bus.req0 && !m_gnt0;
      e1 = bus.req1 && !m_gnt1;
      who = -1;
      if (e0 && e1) who = 1 - last_served;
      else if (e0) who = 0;
      else if (e1) who = 1;
      m_rv0 = 0;
      m_rv1 = 0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        r = pend.pop_front();
        if (r.who == 0) begin m_rv0 = 1; m_rd0 = rom[r.addr]; end
        else begin m_rv1 = 1; m_rd1 = rom[r.addr]; end
      end
      m_gnt0 = (who == 0);
      m_gnt1 = (who == 1);
      if (who >= 0) begin
        a = (who == 0) ? int'(bus.addr0) : int'(bus.addr1);
        m_rom_a = AW'(a);
        last_served = who;
        pend.push_back('{cyc + 1, who, a});
      end
      cyc++;
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("rst_async");
    tick("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] t;
    int k;
    bit [4:0] pat;
    bus.req0 = 0; bus.req1 = 0; bus.addr0 = '0; bus.addr1 = '0;
    for (int i = 0; i < 16; i++) begin
      t = $urandom;
      rom[i] = {t[3:0], 4'(i)};   // distinct contents so a wrong address is visible
    end
    model_reset();

    // Reset state
    tick("reset0");
    tick("reset1");
    @(negedge clk);
    rst_n = 1'b1;

    // Single read from requester 0
    bus.req0 = 1; bus.addr0 = 4'd3;
    tick("single_e0");
    chk("single_gnt0", bus.gnt0, 1);
    bus.req0 = 0;
    tick("single_e1");
    chk("single_rdata0", bus.rdata0, rom[3]);
    chk("single_rvalid0", bus.rvalid0, 1);
    tick("single_idle");

    // Contention immediately after reset: requester 0 wins first
    do_reset();
    bus.req0 = 1; bus.req1 = 1; bus.addr0 = 4'd5; bus.addr1 = 4'd9;
    tick("cont_e0");
    chk("cont_first_gnt0", bus.gnt0, 1);
    bus.req0 = 0;
    tick("cont_e1");
    chk("cont_second_gnt1", bus.gnt1, 1);
    chk("cont_rdata0", bus.rdata0, rom[5]);
    bus.req1 = 0;
    tick("cont_e2");
    chk("cont_rdata1", bus.rdata1, rom[9]);
    tick("cont_idle");

    // Fairness: both held for 8 grants
    n_gnt0 = 0; n_gnt1 = 0;
    bus.req0 = 1; bus.req1 = 1;
    for (int i = 0; i < 8; i++) begin
      bus.addr0 = 4'($urandom); bus.addr1 = 4'($urandom);
      tick("fair");
    end
    bus.req0 = 0; bus.req1 = 0;
    chk("fair_cnt0", n_gnt0, 4);
    chk("fair_cnt1", n_gnt1, 4);
    tick("fair_flush0");
    tick("fair_flush1");

    // Address sweep on requester 1, 0..15 then wrapping back to 0
    n_rv1 = 0;
    k = 0;
    for (int i = 0; i < 38; i++) begin
      if (k < 17) begin bus.req1 = 1; bus.addr1 = 4'(k % 16); end
      else bus.req1 = 0;
      tick("sweep");
      if (m_gnt1) k++;
    end
    chk("sweep_rv1_count", n_rv1, 17);

    // Reset between grant and capture
    bus.req0 = 1; bus.addr0 = 4'd7;
    tick("midrst_e0");
    bus.req0 = 0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("midrst_async");
    tick("midrst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    tick("midrst_post0");
    tick("midrst_post1");
    bus.req0 = 1; bus.req1 = 1; bus.addr0 = 4'd2; bus.addr1 = 4'd4;
    tick("midrst_rr");
    chk("midrst_rr_gnt0", bus.gnt0, 1);
    bus.req0 = 0;
    tick("midrst_rr1");
    bus.req1 = 0;
    tick("midrst_rr2");

    // Withdrawal of req1 and late addr0 changes while requester 0 keeps asking
    pat = 5'b01101;
    for (int i = 0; i < 12; i++) begin
      bus.req0 = 1;
      bus.req1 = pat[i % 5];
      bus.addr1 = 4'($urandom);
      tick("withdraw");
      bus.addr0 = 4'($urandom);   // changes right after each edge, including grant edges
    end
    bus.req0 = 0; bus.req1 = 0;
    tick("withdraw_flush0");
    tick("withdraw_flush1");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      bus.req0 = 1'($urandom);
      bus.req1 = 1'($urandom);
      bus.addr0 = 4'($urandom);
      bus.addr1 = 4'($urandom);
      tick("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
